// File: rtl/text_console_writer.sv
// Writer side of the 80x25 character screen RAM: byte stream in, cursor-tracked cell writes out,
// with CR/LF/BS/form-feed handling and scroll-up. RAM is touched only in granted cycles.
module text_console_writer #(
   parameter int unsigned COLS  = 80,
   parameter int unsigned ROWS  = 25,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        clk,
   input  logic        rst_n_i,
   input  logic [7:0]  char_i,
   input  logic        char_valid_i,
   output logic        char_ready_o,
   input  logic        mem_gnt_i,
   output logic [11:0] mem_addr_o,
   output logic [7:0]  mem_data_o,
   output logic        mem_wren_o,
   input  logic [7:0]  mem_q_i,
   output logic [6:0]  cursor_col_o,
   output logic [4:0]  cursor_row_o,
   output logic        busy_o
);
   localparam int unsigned CW = 7;
   localparam int unsigned RW = 5;

   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PUT, S_CLR, S_SC_RD, S_SC_CAP, S_SC_WR, S_SC_BLK
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col, ptr_col;
   logic [RW-1:0]   row, ptr_row;
   logic [7:0]      ch, cap;
   logic            accept, is_print, is_lf, is_cr, is_bs, is_ff;

   assign accept   = char_valid_i & (state == S_IDLE);
   assign is_print = (char_i >= 8'h20) && (char_i <= 8'h7E);
   assign is_lf    = (char_i == 8'h0A);
   assign is_cr    = (char_i == 8'h0D);
   assign is_bs    = (char_i == 8'h08);
   assign is_ff    = (char_i == 8'h0C);

   // State register
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic; every RAM-touching state stalls until granted
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (is_print)                       state_nxt = S_PUT;
               else if (is_lf && row == ROW_LAST)  state_nxt = S_SC_RD;
               else if (is_ff)                     state_nxt = S_CLR;
            end
         end
         S_PUT: begin
            if (mem_gnt_i)
               state_nxt = (col == COL_LAST && row == ROW_LAST) ? S_SC_RD : S_IDLE;
         end
         S_CLR: begin
            if (mem_gnt_i && ptr_row == ROW_LAST && ptr_col == COL_LAST) state_nxt = S_IDLE;
         end
         S_SC_RD:  if (mem_gnt_i) state_nxt = S_SC_CAP;
         S_SC_CAP: state_nxt = S_SC_WR;
         S_SC_WR: begin
            if (mem_gnt_i)
               state_nxt = (ptr_col == COL_LAST && ptr_row == ROW_LAST) ? S_SC_BLK : S_SC_RD;
         end
         S_SC_BLK: if (mem_gnt_i && ptr_col == COL_LAST) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Cursor, latched byte, scan pointer and captured scroll data
   always_ff @(posedge clk or negedge rst_n_i) begin
      if (!rst_n_i) begin
         col     <= '0;
         row     <= '0;
         ptr_col <= '0;
         ptr_row <= '0;
         ch      <= '0;
         cap     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  ch <= char_i;
                  if (is_lf) begin
                     col <= '0;
                     if (row != ROW_LAST) row <= row + RW'(1);
                     else begin
                        ptr_row <= RW'(1);
                        ptr_col <= '0;
                     end
                  end else if (is_cr) begin
                     col <= '0;
                  end else if (is_bs) begin
                     if (col != '0) col <= col - CW'(1);
                  end else if (is_ff) begin
                     ptr_row <= '0;
                     ptr_col <= '0;
                  end
               end
            end
            S_PUT: begin
               if (mem_gnt_i) begin
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        ptr_row <= RW'(1);
                        ptr_col <= '0;
                     end else begin
                        row <= row + RW'(1);
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            S_CLR: begin
               if (mem_gnt_i) begin
                  if (ptr_col == COL_LAST) begin
                     ptr_col <= '0;
                     if (ptr_row == ROW_LAST) begin
                        col <= '0;
                        row <= '0;
                     end else begin
                        ptr_row <= ptr_row + RW'(1);
                     end
                  end else begin
                     ptr_col <= ptr_col + CW'(1);
                  end
               end
            end
            S_SC_CAP: cap <= mem_q_i;
            S_SC_WR: begin
               // ptr_row parks on the last row, which is the row SC_BLK then blanks
               if (mem_gnt_i) begin
                  if (ptr_col == COL_LAST) begin
                     ptr_col <= '0;
                     if (ptr_row != ROW_LAST) ptr_row <= ptr_row + RW'(1);
                  end else begin
                     ptr_col <= ptr_col + CW'(1);
                  end
               end
            end
            S_SC_BLK: begin
               if (mem_gnt_i) begin
                  if (ptr_col == COL_LAST) begin
                     ptr_col <= '0;
                     col     <= '0;
                     row     <= ROW_LAST;
                  end else begin
                     ptr_col <= ptr_col + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // RAM port drive; write enable follows the grant within the cycle
   always_comb begin
      mem_addr_o = '0;
      mem_data_o = '0;
      mem_wren_o = 1'b0;
      case (state)
         S_PUT: begin
            mem_addr_o = {row, col};
            mem_data_o = ch;
            mem_wren_o = mem_gnt_i;
         end
         S_CLR, S_SC_BLK: begin
            mem_addr_o = {ptr_row, ptr_col};
            mem_data_o = BLANK;
            mem_wren_o = mem_gnt_i;
         end
         S_SC_RD, S_SC_CAP: begin
            mem_addr_o = {ptr_row, ptr_col};
         end
         S_SC_WR: begin
            mem_addr_o = {ptr_row - RW'(1), ptr_col};
            mem_data_o = cap;
            mem_wren_o = mem_gnt_i;
         end
         default: ;
      endcase
   end

   assign char_ready_o = (state == S_IDLE);
   assign busy_o       = (state != S_IDLE);
   assign cursor_col_o = col;
   assign cursor_row_o = row;
endmodule
